// File: rtl/ep2.sv
// Four-input evaluator f = (u & r) | (g ^ x) whose output updates only after the
// input vector has been sampled unchanged STABLE_CYCLES times. Define EP2_COMB_BYPASS_EN for a purely combinational s.
module ep2 #(
  parameter int STABLE_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  output logic s,
  input  logic u,
  input  logic r,
  input  logic g,
  input  logic x
);

  logic [3:0] vec;
  logic       f_val;

  assign vec   = {u, r, g, x};
  assign f_val = (u & r) | (g ^ x);

`ifdef EP2_COMB_BYPASS_EN

  logic unused_clk_rst;
  assign unused_clk_rst = clk ^ rst;
  assign s = f_val;

`else

  localparam int              CW  = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0]   SAT = CW'(STABLE_CYCLES);
  localparam logic [CW-1:0]   ONE = CW'(1);

  logic [3:0]    smp_q, smp_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          s_q, s_d;

  always_comb begin
    smp_d = vec;
    s_d   = s_q;
    if (vec != smp_q)
      cnt_d = ONE;
    else if (cnt_q == SAT)
      cnt_d = cnt_q;
    else
      cnt_d = cnt_q + ONE;
    // s is only rewritten on the edge where the run length reaches the threshold
    if (cnt_d == SAT)
      s_d = f_val;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      smp_q <= 4'b0000;
      cnt_q <= '0;
      s_q   <= 1'b0;
    end else begin
      smp_q <= smp_d;
      cnt_q <= cnt_d;
      s_q   <= s_d;
    end
  end

  assign s = s_q;

`endif

endmodule

// File: tb/tb_ep2.sv
// Directed bench for ep2: default filter (STABLE_CYCLES=2) alongside a
// STABLE_CYCLES=1 instance driven by the same inputs.
module tb_ep2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic u = 1'b0, r = 1'b0, g = 1'b0, x = 1'b0;
  logic s, s1;

  int checks = 0;
  int errors = 0;

  // f truth table from the index list: ones at 1,2,5,6,9,10,12..15
  logic [15:0] ftab = 16'b1111_0110_0110_0110;
  logic [3:0]  prev;

  ep2 #(.STABLE_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .s(s), .u(u), .r(r), .g(g), .x(x)
  );

  ep2 #(.STABLE_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .s(s1), .u(u), .r(r), .g(g), .x(x)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int idx, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s[%0d]: observed=%b expected=%b", tag, idx, obs, exp);
    end
  endtask

  task automatic set_vec(input logic [3:0] v);
    @(negedge clk);
    {u, r, g, x} = v;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // reset asserted between edges with f=1 inputs: s clears immediately
    {u, r, g, x} = 4'b1100;
    #2 rst = 1'b1;
    #1;
    chk("rst_async", 0, s, 1'b0);
    chk("rst_async_sc1", 0, s1, 1'b0);
    tick();
    chk("rst_hold", 0, s, 1'b0);
    chk("rst_hold_sc1", 0, s1, 1'b0);
    @(negedge clk);
    {u, r, g, x} = 4'b0000;
    rst = 1'b0;
    tick();
    chk("rel_e1", 0, s, 1'b0);
    tick();
    chk("rel_e2", 0, s, 1'b0);
    chk("rel_sc1", 0, s1, 1'b0);

    // sweep: s holds old f after first edge, shows new f from the second edge
    prev = 4'd0;
    for (int v = 0; v < 16; v++) begin
      set_vec(4'(v));
      tick();
      chk("sweep_e1", v, s, ftab[prev]);
      chk("sweep_sc1", v, s1, ftab[v]);
      tick();
      chk("sweep_e2", v, s, ftab[v]);
      tick();
      chk("sweep_e3", v, s, ftab[v]);
      prev = 4'(v);
    end

    // one-edge glitch 0001 from a settled 0000 never reaches s
    set_vec(4'b0000);
    tick(); tick(); tick();
    chk("glitch_pre", 0, s, 1'b0);
    set_vec(4'b0001);
    tick();
    chk("glitch_e1", 0, s, 1'b0);
    chk("glitch_sc1", 0, s1, 1'b1);
    set_vec(4'b0000);
    tick();
    chk("glitch_back1", 0, s, 1'b0);
    tick();
    chk("glitch_back2", 0, s, 1'b0);
    chk("glitch_back_sc1", 0, s1, 1'b0);

    // 1100 settles to s=1; a one-edge excursion to 0011 (f=0) is filtered out
    set_vec(4'b1100);
    tick(); tick(); tick();
    chk("hold1100", 0, s, 1'b1);
    set_vec(4'b0011);
    tick();
    chk("excursion", 0, s, 1'b1);
    chk("excursion_sc1", 0, s1, 1'b0);
    set_vec(4'b1100);
    tick();
    chk("return_e1", 0, s, 1'b1);
    tick();
    chk("return_e2", 0, s, 1'b1);

    // asynchronous reset mid-operation, then 2-edge recovery
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("midrst", 0, s, 1'b0);
    chk("midrst_sc1", 0, s1, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    chk("midrst_rel_e1", 0, s, 1'b0);
    chk("midrst_rel_sc1", 0, s1, 1'b1);
    tick();
    chk("midrst_rel_e2", 0, s, 1'b1);

    // single-cycle filter: 0011 -> 0010 flips s1 on the first edge
    set_vec(4'b0011);
    tick(); tick();
    chk("sc1_0011", 0, s1, 1'b0);
    set_vec(4'b0010);
    tick();
    chk("sc1_0010", 0, s1, 1'b1);
    chk("sc2_0010_e1", 0, s, 1'b0);
    tick();
    chk("sc2_0010_e2", 0, s, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
